uart_tx_cfg: RTL
================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter OVERSAMPLING, default 8, oversample ticks per bit, legal 2..16.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, TX FIFO entries, power of 2, legal 2..64.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal 1 or 2.
REQ-005 SHALL have parameter DIV_WIDTH, default 16, width of baud_div_in.
REQ-006 SHALL have port clk_in, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_in, input, 1, reset, asynchronous and active-high.
REQ-008 SHALL have port baud_div_in, input, DIV_WIDTH, oversample tick every baud_div_in+1 clk_in cycles.
REQ-009 SHALL have port tx_valid_in, input, 1, write request.
REQ-010 SHALL have port tx_data_in, input, DATA_BITS, word to transmit.
REQ-011 SHALL have port tx_ready_out, output, 1, FIFO can accept a word.
REQ-012 SHALL have port parity_mode_in, input, 2, 00 none, 01 even, 10 odd, 11 none; present only with UART_TX_PARITY_EN.
REQ-013 SHALL have port tx_serial_out, output, 1, serial line, idle high.
REQ-014 SHALL have port tx_busy_out, output, 1, high while a frame is in progress.
REQ-015 SHALL have port tx_done_out, output, 1, one-cycle pulse at end of each frame.
REQ-016 SHALL have port fifo_level_out, output, clog2(FIFO_DEPTH)+1, words held in FIFO.

Function
REQ-017 SHALL accept a word on a rising edge where tx_valid_in and tx_ready_out are both high; tx_ready_out = (fifo_level_out != FIFO_DEPTH).
REQ-018 SHALL ignore tx_valid_in while full: no overwrite, no level change.
REQ-019 SHALL implement FSM IDLE, START, DATA, PARITY, STOP; PARITY only with UART_TX_PARITY_EN and mode 01/10.
REQ-020 SHALL, in IDLE with FIFO non-empty, pop head word and latch baud_div_in and parity_mode_in, entering START next cycle.
REQ-021 SHALL drive tx_serial_out low exactly 2 cycles after a word is accepted into an empty FIFO while IDLE.
REQ-022 SHALL hold each bit (start, data, parity, stop) for (latched div+1)*OVERSAMPLING cycles exactly; prescaler cleared at frame start.
REQ-023 SHALL send data LSB first.
REQ-024 SHALL hold tx_serial_out high for STOP_BITS bit periods in STOP.
REQ-025 SHALL pulse tx_done_out in the last cycle of the final stop bit.
REQ-026 SHALL, if FIFO non-empty at end of STOP, start the next start bit on the next cycle with no idle bit.
REQ-027 SHALL keep tx_busy_out high from START entry through end of STOP, low otherwise.
REQ-028 SHALL support simultaneous push and pop in one cycle: level unchanged, both words preserved in order.
REQ-029 SHALL ignore baud_div_in and parity_mode_in changes until the next frame start.
REQ-030 SHALL wrap FIFO pointers modulo FIFO_DEPTH.

Reset
REQ-031 SHALL on rst_in high immediately set tx_serial_out=1, tx_busy_out=0, tx_done_out=0, fifo_level_out=0, FSM=IDLE.
REQ-032 SHALL set tx_ready_out=1 during reset, discard FIFO contents and any partial frame, and produce no tx_done_out pulse.

Configuration
REQ-033 SHALL, with UART_TX_PARITY_EN defined, insert one parity bit after data: even = XOR of data bits, odd = its inverse.
REQ-034 SHALL, without UART_TX_PARITY_EN, omit parity_mode_in and the PARITY state; frame = start, data, stop.

Verification
REQ-035 SHALL test reset: rst_in pulsed mid-DATA -> tx_serial_out high same cycle, busy 0, level 0, no done pulse.
REQ-036 SHALL test single frame: OVERSAMPLING=8, div=0, push 0xA5 -> low 8 cycles, then 1,0,1,0,0,1,0,1, stop high; done 80 cycles after start falls.
REQ-037 SHALL test burst: push 0x23,0x25,0xFF,0x13,0x00 on consecutive cycles -> first popped, four queued, level 4, tx_ready_out low; five contiguous frames.
REQ-038 SHALL test parity: 0x07 even -> parity 1; 0x07 odd -> parity 0; frame 88 cycles at div=0.
REQ-039 SHALL test STOP_BITS=2, div=3 -> bit period 32 cycles, stop high 64 cycles.
REQ-040 SHALL test div change: div 0->1 mid-frame -> current frame keeps 8-cycle bits; next frame uses 16.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: FIFO-buffered UART transmitter with programmable baud divider.
//
// Build option: UART_TX_PARITY_EN adds parity_mode_in and a PARITY state
// (00 none, 01 even, 10 odd, 11 none).
//
// Ports:
//   clk_in, rst_in       clock, asynchronous active-high reset
//   baud_div_in          oversample tick every baud_div_in+1 cycles (latched per frame)
//   tx_valid_in/ready    write handshake into the TX FIFO
//   tx_data_in           word to send, LSB first
//   parity_mode_in       parity select (only with UART_TX_PARITY_EN, latched per frame)
//   tx_serial_out        serial line, idle high
//   tx_busy_out          high for the whole frame as seen on the line
//   tx_done_out          one-cycle pulse in the last cycle of the final stop bit
//   fifo_level_out       words held in the FIFO
module uart_tx_cfg #(
  parameter int DATA_BITS    = 8,
  parameter int OVERSAMPLING = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1,
  parameter int DIV_WIDTH    = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [DIV_WIDTH-1:0]          baud_div_in,
  input  logic                          tx_valid_in,
  input  logic [DATA_BITS-1:0]          tx_data_in,
  output logic                          tx_ready_out,
`ifdef UART_TX_PARITY_EN
  input  logic [1:0]                    parity_mode_in,
`endif
  output logic                          tx_serial_out,
  output logic                          tx_busy_out,
  output logic                          tx_done_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out
);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = PW + 1;
  localparam int OSW = $clog2(OVERSAMPLING);
  localparam int BW  = 4;
  localparam logic [OSW-1:0] OS_LAST   = OSW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0]  DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0]  STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [LW-1:0]  DEPTH_L   = LW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   presc_q, presc_d, div_q, div_d;
  logic [OSW-1:0]         os_q, os_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   serial_q, serial_d, busy_q, busy_d, done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d, par_en_q, par_en_d;
`endif
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

  logic push, pop, tick, bit_end, last_stop;

  assign tx_ready_out   = (level_q != DEPTH_L);
  assign push           = tx_valid_in && tx_ready_out;
  assign tick           = (presc_q == div_q);
  assign bit_end        = tick && (os_q == OS_LAST);
  assign last_stop      = (state_q == STOP) && bit_end && (bit_q == STOP_LAST);

  // Outputs are registered from the current state, so the line, busy and
  // done all lag the FSM by one cycle and stay mutually aligned.
  assign tx_serial_out  = serial_q;
  assign tx_busy_out    = busy_q;
  assign tx_done_out    = done_q;
  assign fifo_level_out = level_q;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    div_d    = div_q;
    os_d     = os_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop      = 1'b0;
    done_d   = 1'b0;
    busy_d   = (state_q != IDLE);
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
    par_en_d = par_en_q;
`endif

    case (state_q)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shreg_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_d = par_q;
`endif
      default: serial_d = 1'b1;
    endcase

    // Prescaler and oversample counter run only inside a frame.
    if (state_q != IDLE) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) os_d = (os_q == OS_LAST) ? '0 : os_q + 1'b1;
    end

    case (state_q)
      IDLE: ;
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (bit_end) begin
        shreg_d = shreg_q >> 1;
        if (bit_q == DATA_LAST) begin
          bit_d   = '0;
`ifdef UART_TX_PARITY_EN
          state_d = par_en_q ? PARITY : STOP;
`else
          state_d = STOP;
`endif
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) begin
        state_d = STOP;
        bit_d   = '0;
      end
`endif
      STOP: if (bit_end) begin
        if (bit_q == STOP_LAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame start: from IDLE, or straight out of the final stop cycle so
    // queued words go out back to back with no idle bit.
    if ((level_q != '0) && ((state_q == IDLE) || last_stop)) begin
      pop      = 1'b1;
      state_d  = START;
      shreg_d  = mem_q[rd_ptr_q];
      div_d    = baud_div_in;
      presc_d  = '0;
      os_d     = '0;
      bit_d    = '0;
      rd_ptr_d = rd_ptr_q + 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_d = (parity_mode_in == 2'b01) || (parity_mode_in == 2'b10);
      par_d    = (^mem_q[rd_ptr_q]) ^ (parity_mode_in == 2'b10);
`endif
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      div_q    <= '0;
      os_q     <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      div_q    <= div_d;
      os_q     <= os_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
      par_en_q <= par_en_d;
`endif
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= tx_data_in;
  end

endmodule
